// File: rtl/cplx_acc_dump.sv
// cplx_acc_dump: captures completed complex accumulator windows, rounds and
// saturates them to OW bits, and queues the results in a small output FIFO.
// The sload strobe is delayed to line up with the accumulator's completed sum.
// The first capture after reset is skipped because no full window precedes it.
module cplx_acc_dump #(
  parameter int PW       = 40,
  parameter int OW       = 16,
  parameter int SHIFT    = 16,
  parameter int DUMP_DLY = 6,
  parameter int DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sload,
  input  logic signed [PW-1:0] pr,
  input  logic signed [PW-1:0] pi,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2*OW + 1;
  localparam logic signed [PW:0] RND  = (PW+1)'(1) << (SHIFT-1);
  localparam logic signed [PW:0] MAXV = {{(PW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [PW:0] MINV = ~MAXV;

  // Round half-up with one guard bit so the +half addition can never wrap,
  // then clamp to the OW-bit signed range; the MSB of the result flags a clamp.
  function automatic logic [OW:0] rnd_sat(input logic signed [PW-1:0] x);
    logic signed [PW:0] s;
    s = $signed({x[PW-1], x}) + RND;
    s = s >>> SHIFT;
    if (s > MAXV)
      rnd_sat = {1'b1, MAXV[OW-1:0]};
    else if (s < MINV)
      rnd_sat = {1'b1, MINV[OW-1:0]};
    else
      rnd_sat = {1'b0, s[OW-1:0]};
  endfunction

  logic [DUMP_DLY-1:0] r_sload_dly;
  logic                r_primed;
  logic                r_rnd_vld;
  logic [EW-1:0]       r_rnd_data;
  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW:0]         r_wp;
  logic [AW:0]         r_rp;
  logic                r_ovf;

  logic          w_cap;
  logic          w_cap_ok;
  logic [OW:0]   w_re_rs;
  logic [OW:0]   w_im_rs;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;

  assign w_cap    = r_sload_dly[DUMP_DLY-1];
  assign w_cap_ok = w_cap & r_primed;
  assign w_re_rs  = rnd_sat(pr);
  assign w_im_rs  = rnd_sat(pi);

  // sload delay line and primed flag; the first delayed strobe only arms capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sload_dly <= '0;
      r_primed    <= 1'b0;
    end else begin
      r_sload_dly <= (r_sload_dly << 1) | DUMP_DLY'(sload);
      if (w_cap)
        r_primed <= 1'b1;
    end
  end

  // Rounding/saturation register stage, loaded on each accepted capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd_vld  <= 1'b0;
      r_rnd_data <= '0;
    end else begin
      r_rnd_vld <= w_cap_ok;
      if (w_cap_ok)
        r_rnd_data <= {w_re_rs[OW] | w_im_rs[OW], w_re_rs[OW-1:0], w_im_rs[OW-1:0]};
    end
  end

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = ~w_empty & out_ready;
  assign w_push  = r_rnd_vld & (~w_full | w_pop);
  assign w_drop  = r_rnd_vld & w_full & ~w_pop;
  assign w_head  = r_mem[r_rp[AW-1:0]];

  // FIFO storage; a push into a full FIFO with a pop reuses the slot being read
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp[AW-1:0]] <= r_rnd_data;
  end

  // FIFO pointers and sticky overflow flag (a new drop beats a clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign out_valid = ~w_empty;
  assign out_sat   = out_valid & w_head[EW-1];
  assign out_re    = out_valid ? w_head[2*OW-1:OW] : '0;
  assign out_im    = out_valid ? w_head[OW-1:0] : '0;
  assign ovf       = r_ovf;

endmodule
